// File: rtl/hdmi_out_sequencer.sv
// Output-side video sequencer for the ADV7513 path: waits for the transmitter to be
// configured, resyncs the scaler, mutes a few frames after lock, then passes video.
module hdmi_out_sequencer #(
  parameter int unsigned MUTE_FRAMES    = 2,
  parameter int unsigned RESYNC_CYCLES  = 16,
  parameter bit          VS_ACTIVE_HIGH = 1'b1
) (
  input  logic        HDMI_CLK_w,
  input  logic        HDMI_nRST_w,
  input  logic        cfg_done_i,
  input  logic [3:0]  target_res_i,
  input  logic        VSYNC_i,
  input  logic        HSYNC_i,
  input  logic        DE_i,
  input  logic [23:0] VD_i,
  output logic        VSYNC_o,
  output logic        HSYNC_o,
  output logic        DE_o,
  output logic [23:0] VD_o,
  output logic        scaler_nresync_o,
  output logic        video_active_o
);

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    RESYNC  = 3'd1,
    WAIT_VS = 3'd2,
    MUTE    = 3'd3,
    RUN     = 3'd4
  } state_t;

  localparam logic [7:0] RCNT_INIT = 8'(RESYNC_CYCLES);
  localparam logic [3:0] FCNT_INIT = 4'(MUTE_FRAMES);

  state_t     state, state_d;
  logic [7:0] rcnt, rcnt_d;
  logic [3:0] fcnt, fcnt_d;
  logic [3:0] res_q, res_d;

  logic       cfg_meta, cfg_sync;
  logic [3:0] res_meta, res_sync, res_prev;
  logic       vs_r, vs_prev;

  logic frame_edge, res_change, pass_sync, pass_data;

  always_ff @(posedge HDMI_CLK_w or negedge HDMI_nRST_w) begin
    if (!HDMI_nRST_w) begin
      cfg_meta <= 1'b0;
      cfg_sync <= 1'b0;
      res_meta <= '0;
      res_sync <= '0;
      res_prev <= '0;
      vs_r     <= 1'b0;
      vs_prev  <= 1'b0;
    end else begin
      cfg_meta <= cfg_done_i;
      cfg_sync <= cfg_meta;
      res_meta <= target_res_i;
      res_sync <= res_meta;
      res_prev <= res_sync;
      vs_r     <= VSYNC_i;
      vs_prev  <= vs_r;
    end
  end

  assign frame_edge = (vs_r == VS_ACTIVE_HIGH) && (vs_prev != VS_ACTIVE_HIGH);
  // A new code must survive two synchronized samples so a torn multi-bit capture is ignored.
  assign res_change = (res_sync == res_prev) && (res_sync != res_q);

  always_ff @(posedge HDMI_CLK_w or negedge HDMI_nRST_w) begin
    if (!HDMI_nRST_w) begin
      state <= OFF;
      rcnt  <= '0;
      fcnt  <= '0;
      res_q <= '0;
    end else begin
      state <= state_d;
      rcnt  <= rcnt_d;
      fcnt  <= fcnt_d;
      res_q <= res_d;
    end
  end

  always_comb begin
    state_d = state;
    rcnt_d  = rcnt;
    fcnt_d  = fcnt;
    res_d   = res_q;
    if (!cfg_sync) begin
      state_d = OFF;
    end else if (state == OFF) begin
      state_d = RESYNC;
      rcnt_d  = RCNT_INIT;
      res_d   = res_sync;
    end else if (res_change && (state inside {RESYNC, WAIT_VS, MUTE, RUN})) begin
      state_d = RESYNC;
      rcnt_d  = RCNT_INIT;
      res_d   = res_sync;
    end else begin
      case (state)
        RESYNC: begin
          if (rcnt != 8'd0) rcnt_d = rcnt - 8'd1;
          if (rcnt <= 8'd1) state_d = WAIT_VS;
        end
        WAIT_VS: begin
          if (frame_edge) begin
            if (FCNT_INIT == 4'd0) begin
              state_d = RUN;
            end else begin
              state_d = MUTE;
              fcnt_d  = FCNT_INIT;
            end
          end
        end
        MUTE: begin
          if (frame_edge) begin
            if (fcnt != 4'd0) fcnt_d = fcnt - 4'd1;
            if (fcnt <= 4'd1) state_d = RUN;
          end
        end
        RUN:     state_d = RUN;
        default: state_d = OFF;
      endcase
    end
  end

  // Gating follows the next state so outputs and video_active switch on the state-entry clock.
  assign pass_sync = state_d inside {WAIT_VS, MUTE, RUN};
  assign pass_data = (state_d == RUN);

  always_ff @(posedge HDMI_CLK_w or negedge HDMI_nRST_w) begin
    if (!HDMI_nRST_w) begin
      VSYNC_o          <= 1'b0;
      HSYNC_o          <= 1'b0;
      DE_o             <= 1'b0;
      VD_o             <= '0;
      scaler_nresync_o <= 1'b0;
      video_active_o   <= 1'b0;
    end else begin
      VSYNC_o          <= pass_sync & VSYNC_i;
      HSYNC_o          <= pass_sync & HSYNC_i;
      DE_o             <= pass_data & DE_i;
      VD_o             <= pass_data ? VD_i : 24'h0;
      scaler_nresync_o <= pass_sync;
      video_active_o   <= pass_data;
    end
  end

endmodule

// File: tb/tb_hdmi_out_sequencer.sv
// Directed bench: a default-parameter sequencer and a fast one (no mute, 1-clock resync)
// share the same stimulus; each cycle both output vectors are checked against expected modes.
module tb_hdmi_out_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg = 1'b0;
  logic [3:0]  res = 4'h2;
  logic        vs = 1'b0, hs = 1'b0, de = 1'b0;
  logic [23:0] vd = '0;

  logic        a_vs, a_hs, a_de, a_nres, a_act;
  logic [23:0] a_vd;
  logic        b_vs, b_hs, b_de, b_nres, b_act;
  logic [23:0] b_vd;
  logic [28:0] act_a, act_b;

  int tests = 0;
  int fails = 0;
  int fno   = 0;

  always #5 clk = ~clk;

  hdmi_out_sequencer dut (
    .HDMI_CLK_w(clk), .HDMI_nRST_w(rst_n), .cfg_done_i(cfg), .target_res_i(res),
    .VSYNC_i(vs), .HSYNC_i(hs), .DE_i(de), .VD_i(vd),
    .VSYNC_o(a_vs), .HSYNC_o(a_hs), .DE_o(a_de), .VD_o(a_vd),
    .scaler_nresync_o(a_nres), .video_active_o(a_act)
  );

  hdmi_out_sequencer #(.MUTE_FRAMES(0), .RESYNC_CYCLES(1), .VS_ACTIVE_HIGH(1'b1)) dut0 (
    .HDMI_CLK_w(clk), .HDMI_nRST_w(rst_n), .cfg_done_i(cfg), .target_res_i(res),
    .VSYNC_i(vs), .HSYNC_i(hs), .DE_i(de), .VD_i(vd),
    .VSYNC_o(b_vs), .HSYNC_o(b_hs), .DE_o(b_de), .VD_o(b_vd),
    .scaler_nresync_o(b_nres), .video_active_o(b_act)
  );

  assign act_a = {a_vs, a_hs, a_de, a_vd, a_nres, a_act};
  assign act_b = {b_vs, b_hs, b_de, b_vd, b_nres, b_act};

  // mode 0: dark (OFF/RESYNC), 1: syncs only (WAIT_VS/MUTE), 2: full pass (RUN)
  function automatic logic [28:0] expv(input logic [1:0] m, input logic v, h, d,
                                       input logic [23:0] px);
    case (m)
      2'd1:    return {v, h, 1'b0, 24'h0, 1'b1, 1'b0};
      2'd2:    return {v, h, d, px, 1'b1, 1'b1};
      default: return 29'h0;
    endcase
  endfunction

  task automatic cyc(input logic v, h, d, input logic [23:0] px,
                     input logic [1:0] ma, mb, input string nm);
    logic [28:0] ea, eb;
    vs = v; hs = h; de = d; vd = px;
    @(posedge clk); #1;
    ea = expv(ma, v, h, d, px);
    eb = expv(mb, v, h, d, px);
    tests++;
    if (act_a !== ea) begin
      fails++;
      $display("FAIL %s dut: got %h expected %h", nm, act_a, ea);
    end
    tests++;
    if (act_b !== eb) begin
      fails++;
      $display("FAIL %s dut0: got %h expected %h", nm, act_b, eb);
    end
  endtask

  // 12-cycle frame: VSYNC on cycles 0-1, active video on 3-9; mode switches at index sw
  task automatic frame(input int swa, input logic [1:0] a0, a1,
                       input int swb, input logic [1:0] b0, b1, input string nm);
    for (int i = 0; i < 12; i++)
      cyc(i < 2, (i % 3) == 0, (i >= 3) && (i <= 9), {8'(fno), 8'(i), 8'h5A ^ 8'(i)},
          (i < swa) ? a0 : a1, (i < swb) ? b0 : b1, nm);
    fno++;
  endtask

  // Clocks from the caller's cfg/reset release until scaler_nresync_o rises on each DUT.
  task automatic lock_count(input string nm);
    int na = 0, nb = 0;
    vs = 1'b0; hs = 1'b0; de = 1'b0; vd = '0;
    for (int n = 1; n <= 60 && (na == 0 || nb == 0); n++) begin
      @(posedge clk); #1;
      if (na == 0 && a_nres) na = n;
      if (nb == 0 && b_nres) nb = n;
    end
    tests++;
    if (na !== 19) begin
      fails++;
      $display("FAIL %s dut nresync rise clock: got %0d expected 19", nm, na);
    end
    tests++;
    if (nb !== 4) begin
      fails++;
      $display("FAIL %s dut0 nresync rise clock: got %0d expected 4", nm, nb);
    end
  endtask

  task automatic lock_frames(input string nm);
    frame(99, 2'd1, 2'd1, 1, 2'd1, 2'd2, nm);
    frame(99, 2'd1, 2'd1, 0, 2'd2, 2'd2, nm);
    frame(1,  2'd1, 2'd2, 0, 2'd2, 2'd2, nm);
  endtask

  task automatic test_reset();
    cfg = 1'b1;
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b1, 1'b1, 24'hFFFFFF, 2'd0, 2'd0, "reset_hold");
  endtask

  task automatic test_lock();
    rst_n = 1'b1;
    lock_count("lock_after_reset");
  endtask

  task automatic test_mute_to_run();
    lock_frames("mute_to_run");
    frame(0, 2'd2, 2'd2, 0, 2'd2, 2'd2, "run_pass");
  endtask

  task automatic test_glitch();
    res = 4'h5;
    cyc(1'b0, 1'b1, 1'b1, 24'h123456, 2'd2, 2'd2, "res_glitch");
    res = 4'h2;
    for (int i = 0; i < 6; i++)
      cyc(1'b0, i[0], 1'b1, {8'hAB, 8'(i), 8'hCD}, 2'd2, 2'd2, "res_glitch");
    frame(0, 2'd2, 2'd2, 0, 2'd2, 2'd2, "res_glitch_frame");
  endtask

  task automatic test_res_change();
    res = 4'h5;
    for (int i = 0; i < 22; i++)
      cyc(1'b0, i[0], 1'b1, {8'hC0, 8'(i), 8'h3C},
          (i < 3) ? 2'd2 : (i < 19) ? 2'd0 : 2'd1,
          (i < 3) ? 2'd2 : (i == 3) ? 2'd0 : 2'd1, "res_change");
  endtask

  task automatic test_cfg_drop();
    // first frame after resync: dut enters MUTE, dut0 goes straight to RUN
    for (int i = 0; i < 12; i++) begin
      if (i == 10) res = 4'h7;
      if (i == 11) cfg = 1'b0;
      cyc(i < 2, (i % 3) == 0, (i >= 3) && (i <= 9), {8'(fno), 8'(i), 8'h5A ^ 8'(i)},
          2'd1, (i < 1) ? 2'd1 : 2'd2, "cfg_drop_pre");
    end
    fno++;
    // cfg loss, res change and frame edge all land on the same clock
    for (int i = 0; i < 12; i++)
      cyc(i < 2, (i % 3) == 0, (i >= 3) && (i <= 9), {8'(fno), 8'(i), 8'h5A ^ 8'(i)},
          (i < 1) ? 2'd1 : 2'd0, (i < 1) ? 2'd2 : 2'd0, "cfg_drop");
    fno++;
    for (int i = 0; i < 20; i++)
      cyc(1'b0, 1'b1, 1'b1, 24'h777777, 2'd0, 2'd0, "cfg_drop_stays_off");
    cfg = 1'b1;
    lock_count("relock_after_cfg");
  endtask

  task automatic test_async_reset();
    lock_frames("pre_async_reset");
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 1'b1, {8'hEE, 8'(i), 8'h11}, 2'd2, 2'd2, "mid_line");
    #3 rst_n = 1'b0;
    #1;
    tests++;
    if (act_a !== 29'h0) begin
      fails++;
      $display("FAIL async_reset dut: got %h expected 0", act_a);
    end
    tests++;
    if (act_b !== 29'h0) begin
      fails++;
      $display("FAIL async_reset dut0: got %h expected 0", act_b);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    lock_count("lock_after_async_reset");
    lock_frames("relock_after_async_reset");
  endtask

  initial begin
    test_reset();
    test_lock();
    test_mute_to_run();
    test_glitch();
    test_res_change();
    test_cfg_drop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
